pagerank_result_tx: RTL and testbench
=====================================

PAGERANK_RESULT_TX -- requirements
Module: pagerank_result_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 31: rank-engine word width; value field width VW = WIDTH-7 (24 at default).
REQ-002 SHALL have parameter K, default 10: number of ranked entries per result set.
REQ-003 SHALL have parameter IDW, default 6: node ID width.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1: reset is asynchronous and active-high.
REQ-006 SHALL have port top10Vals, input, K*VW: ranked values; entry k at bits [k*VW +: VW]; entry 0 is rank 0 (highest).
REQ-007 SHALL have port top10IDs, input, K*IDW: ranked node IDs; entry k at bits [k*IDW +: IDW].
REQ-008 SHALL have port done, input, 1: level from the rank engine; high while top10Vals/top10IDs are valid.
REQ-009 SHALL have port out_valid, output, 1: a beat is presented.
REQ-010 SHALL have port out_ready, input, 1: sink accepts the beat.
REQ-011 SHALL have port out_rank, output, 4: rank index 0..K-1 of the current beat.
REQ-012 SHALL have port out_id, output, IDW: node ID of the current beat.
REQ-013 SHALL have port out_val, output, VW: rank value of the current beat.
REQ-014 SHALL have port out_last, output, 1: high on the beat with out_rank = K-1.
REQ-015 SHALL have port busy, output, 1: high in LOAD or SEND.
REQ-016 SHALL have port frame_cnt, output, 8: number of completed result frames, wraps 255->0.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SEND, WAIT_CLR.
REQ-018 IDLE: on a cycle where done=1 and the registered done of the previous cycle was 0 (rising edge), SHALL go to LOAD; otherwise stay.
REQ-019 LOAD: SHALL snapshot top10Vals and top10IDs into internal shadow registers in one cycle, set the rank index to 0, and go to SEND; subsequent input changes SHALL NOT affect the frame.
REQ-020 SEND: SHALL assert out_valid with out_rank = index, out_id/out_val from shadow entry index, out_last = (index == K-1).
REQ-021 A beat transfers when out_valid and out_ready are both 1 on a rising edge; out_rank/out_id/out_val/out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 On a transfer with index < K-1, the index SHALL increment by 1; the next beat SHALL be presented in the following cycle (zero bubble; one beat per cycle under continuous out_ready).
REQ-023 On the transfer with index = K-1, frame_cnt SHALL increment by 1 (modulo 256), out_valid SHALL drop next cycle, and the FSM SHALL go to WAIT_CLR.
REQ-024 WAIT_CLR: SHALL go to IDLE when done=0; while done stays 1 no new frame SHALL start (one frame per done assertion).
REQ-025 A done rising edge during LOAD, SEND, or WAIT_CLR SHALL be ignored; no frame queuing.
REQ-026 done falling during SEND SHALL NOT abort the frame; all K beats SHALL still be sent from the shadow registers, then WAIT_CLR exits next cycle since done=0.
REQ-027 Outside SEND, out_valid and out_last SHALL be 0; out_rank/out_id/out_val hold their last value.
REQ-028 Latency: first out_valid SHALL be asserted 2 cycles after the cycle in which done is first sampled high (edge detect cycle, LOAD cycle).

Reset
REQ-029 On reset=1, asynchronously: FSM=IDLE, out_valid=0, out_last=0, busy=0, out_rank=0, out_id=0, out_val=0, frame_cnt=0, shadow registers=0, registered done=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame immediately; after release, if done is already 1, a new frame SHALL start (registered done cleared to 0 makes it a rising edge).

Verification
REQ-031 Load entries val_k = 0x100000-k, id_k = k+5, pulse done high, out_ready=1 -> 10 consecutive beats, ranks 0..9, ids 5..14, vals 0x100000..0x0FFFF7, out_last only on rank 9, frame_cnt=1.
REQ-032 Same data, out_ready toggling 1,0,1,0... -> 10 beats in order, outputs stable on stalled cycles, no beat lost or duplicated.
REQ-033 Change top10Vals/top10IDs to all-ones during SEND -> streamed frame still matches the snapshot values.
REQ-034 Hold done=1 for 40 cycles -> exactly one frame; drop done, raise again -> second frame, frame_cnt=2.
REQ-035 Assert reset at rank 4 with done still 1, release -> all outputs zero during reset, then full new frame starting at rank 0, frame_cnt=1.
REQ-036 Run 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/pagerank_result_tx.sv
// Streams a snapshot of the rank engine's top-K list as one valid/ready beat
// per entry, one frame per rising edge of done.
module pagerank_result_tx #(
   parameter int WIDTH = 31,
   parameter int K     = 10,
   parameter int IDW   = 6
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [K*(WIDTH-7)-1:0]      top10Vals,
   input  logic [K*IDW-1:0]            top10IDs,
   input  logic                        done,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [3:0]                  out_rank,
   output logic [IDW-1:0]              out_id,
   output logic [WIDTH-8:0]            out_val,
   output logic                        out_last,
   output logic                        busy,
   output logic [7:0]                  frame_cnt
);
   localparam int VW = WIDTH - 7;

   typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_CLR} state_t;

   state_t            r_state, w_next;
   logic              r_done;
   logic [K*VW-1:0]   r_vals;
   logic [K*IDW-1:0]  r_ids;
   logic [3:0]        r_idx;
   logic [7:0]        r_frame_cnt;

   logic              w_rise, w_xfer, w_at_last;
   logic [VW-1:0]     w_val;
   logic [IDW-1:0]    w_id;

   assign w_rise    = done & ~r_done;
   assign w_at_last = (r_idx == 4'(K-1));
   assign w_xfer    = (r_state == SEND) & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (w_rise) w_next = LOAD;
         LOAD:     w_next = SEND;
         SEND:     if (w_xfer && w_at_last) w_next = WAIT_CLR;
         WAIT_CLR: if (!done) w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   always_comb begin
      out_valid = (r_state == SEND);
      out_last  = (r_state == SEND) && w_at_last;
      busy      = (r_state == LOAD) || (r_state == SEND);
   end

   // Shadow copy decouples the frame from the engine; index and shadow hold
   // after the frame so the beat fields keep their last value when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_done      <= 1'b0;
         r_vals      <= '0;
         r_ids       <= '0;
         r_idx       <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_done <= done;
         if (r_state == LOAD) begin
            r_vals <= top10Vals;
            r_ids  <= top10IDs;
            r_idx  <= '0;
         end else if (w_xfer) begin
            if (w_at_last) r_frame_cnt <= r_frame_cnt + 8'd1;
            else           r_idx       <= r_idx + 4'd1;
         end
      end
   end

   always_comb begin
      w_val = '0;
      w_id  = '0;
      for (int k = 0; k < K; k++) begin
         if (r_idx == 4'(k)) begin
            w_val = r_vals[k*VW +: VW];
            w_id  = r_ids[k*IDW +: IDW];
         end
      end
   end

   assign out_rank  = r_idx;
   assign out_id    = w_id;
   assign out_val   = w_val;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_pagerank_result_tx.sv
// Directed bench for pagerank_result_tx: streaming, stalls, snapshot
// isolation, one-frame-per-done, mid-frame reset and frame counter wrap.
module tb_pagerank_result_tx;
   localparam int WIDTH = 31;
   localparam int K     = 10;
   localparam int IDW   = 6;
   localparam int VW    = WIDTH - 7;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [K*VW-1:0]      top10Vals;
   logic [K*IDW-1:0]     top10IDs;
   logic                 done;
   logic                 out_valid;
   logic                 out_ready;
   logic [3:0]           out_rank;
   logic [IDW-1:0]       out_id;
   logic [VW-1:0]        out_val;
   logic                 out_last;
   logic                 busy;
   logic [7:0]           frame_cnt;

   int checks = 0;
   int errors = 0;

   pagerank_result_tx #(.WIDTH(WIDTH), .K(K), .IDW(IDW)) dut (
      .clk(clk), .reset(reset), .top10Vals(top10Vals), .top10IDs(top10IDs),
      .done(done), .out_valid(out_valid), .out_ready(out_ready),
      .out_rank(out_rank), .out_id(out_id), .out_val(out_val),
      .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_data();
      for (int k = 0; k < K; k++) begin
         top10Vals[k*VW +: VW]  = 24'h100000 - 24'(k);
         top10IDs[k*IDW +: IDW] = 6'(k + 5);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      done = 1'b0; out_ready = 1'b1; reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Collect nb beats; stall=1 toggles out_ready, corrupt=1 trashes the
   // inputs mid-frame. With nb==K, also checks the cycle after the last beat.
   task automatic recv(input bit stall, input bit corrupt, input int nb);
      int n = 0;
      int cyc = 0;
      while (n < nb && cyc < 100) begin
         @(negedge clk);
         out_ready = stall ? ~cyc[0] : 1'b1;
         if (corrupt && n == 2) begin
            top10Vals = '1;
            top10IDs  = '1;
         end
         if (out_valid) begin
            chk("rank", 32'(out_rank), 32'(n));
            chk("id",   32'(out_id),   32'(n + 5));
            chk("val",  32'(out_val),  32'h100000 - 32'(n));
            chk("last", 32'(out_last), 32'(n == K-1));
            if (out_ready) n++;
         end
         cyc++;
      end
      if (n < nb) chk("recv_timeout", 32'(n), 32'(nb));
      if (nb == K) begin
         @(negedge clk);
         chk("valid_after", 32'(out_valid), 32'd0);
         chk("last_after",  32'(out_last),  32'd0);
         chk("rank_hold",   32'(out_rank),  32'(K-1));
      end
   endtask

   task automatic start_frame();
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      chk("lat_valid0", 32'(out_valid), 32'd0);
      chk("lat_busy",   32'(busy),      32'd1);
   endtask

   task automatic quiet_frame();
      int cyc = 0;
      @(negedge clk);
      done = 1'b1; out_ready = 1'b1;
      while (!(out_valid && out_last) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 50) chk("quiet_timeout", 32'd0, 32'd1);
      @(negedge clk);
      done = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int vcount;
      reset = 1'b1; done = 1'b0; out_ready = 1'b0;
      top10Vals = '0; top10IDs = '0;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_rank",  32'(out_rank),  32'd0);
      chk("rst_id",    32'(out_id),    32'd0);
      chk("rst_val",   32'(out_val),   32'd0);
      chk("rst_fcnt",  32'(frame_cnt), 32'd0);
      load_data();
      do_reset();

      // continuous ready, then first out_valid two cycles after done
      start_frame();
      recv(1'b0, 1'b0, K);
      chk("fcnt_t1", 32'(frame_cnt), 32'd1);
      done = 1'b0;

      do_reset();
      start_frame();
      recv(1'b1, 1'b0, K);
      chk("fcnt_t2", 32'(frame_cnt), 32'd1);
      done = 1'b0;

      do_reset();
      start_frame();
      recv(1'b0, 1'b1, K);
      chk("fcnt_t3", 32'(frame_cnt), 32'd1);
      load_data();
      done = 1'b0;

      // done held high across and beyond one frame
      do_reset();
      start_frame();
      recv(1'b0, 1'b0, K);
      vcount = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (out_valid || busy) vcount++;
      end
      chk("one_frame", 32'(vcount), 32'd0);
      chk("fcnt_t4a", 32'(frame_cnt), 32'd1);
      done = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start_frame();
      recv(1'b0, 1'b0, K);
      chk("fcnt_t4b", 32'(frame_cnt), 32'd2);
      done = 1'b0;

      // reset mid-frame with done still high
      do_reset();
      start_frame();
      recv(1'b0, 1'b0, 4);
      @(negedge clk);
      chk("pre_rst_rank", 32'(out_rank), 32'd4);
      reset = 1'b1;
      #1;
      chk("mr_valid", 32'(out_valid), 32'd0);
      chk("mr_rank",  32'(out_rank),  32'd0);
      chk("mr_id",    32'(out_id),    32'd0);
      chk("mr_val",   32'(out_val),   32'd0);
      chk("mr_busy",  32'(busy),      32'd0);
      chk("mr_fcnt",  32'(frame_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("mr_restart_busy", 32'(busy), 32'd1);
      recv(1'b0, 1'b0, K);
      chk("fcnt_t5", 32'(frame_cnt), 32'd1);
      done = 1'b0;

      // frame counter wrap
      do_reset();
      for (int f = 0; f < 255; f++) quiet_frame();
      chk("fcnt_255", 32'(frame_cnt), 32'd255);
      quiet_frame();
      chk("fcnt_wrap", 32'(frame_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
